dv_close_cal_ctrl: RTL and testbench

- Calibration sequencer for the diaphragm-valve feedback path.
- On request, it drives each of the six plungers closed in turn and waits a settle time. It then averages the plunger ADC sense count and stores the result as that plunger's closing limit.
- When all six are done, it pulses a load strobe so the feedback block latches the new limits.
- Sits between the host command/register block and the valve feedback block; its close-value outputs feed the feedback block's close-limit inputs.

---
 rtl/dv_close_cal_ctrl_if.sv | 24 ++
 rtl/dv_close_cal_ctrl.sv | 130 +++++++++++++
 tb/tb_dv_close_cal_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dv_close_cal_ctrl_if.sv
// Host/feedback-side signal bundle of the diaphragm-valve closing-limit calibration sequencer.
// The master modport drives the stimulus; the slave modport is the sequencer itself.
interface dv_close_cal_ctrl_if;
    logic        sample_strb;
    logic        cal_start;
    logic        cal_abort;
    logic [59:0] sense;
    logic [5:0]  valve_cmd;
    logic [59:0] close_val;
    logic        strb_load;
    logic        cal_busy;
    logic        cal_done;
    logic [5:0]  cal_err;

    modport master (
        output sample_strb, cal_start, cal_abort, sense,
        input  valve_cmd, close_val, strb_load, cal_busy, cal_done, cal_err
    );

    modport slave (
        input  sample_strb, cal_start, cal_abort, sense,
        output valve_cmd, close_val, strb_load, cal_busy, cal_done, cal_err
    );
endinterface

// File: rtl/dv_close_cal_ctrl.sv
// Closes each of six plungers in turn, averages its ADC sense count and stores it as its close limit (DV_CAL_MAX_CHECK_EN adds an upper-limit check).
// Latency: per plunger SETTLE_TICKS + 2^AVG_SHIFT sample strobes + 3 clks; strb_load pulses 2 clks after the last STORE.
// No backpressure: start is ignored while busy, abort returns to idle on the next clk.
module dv_close_cal_ctrl #(
    parameter logic [7:0] SETTLE_TICKS  = 8'd50,
    parameter int         AVG_SHIFT     = 2,
    parameter logic [9:0] MIN_CLOSE_CNT = 10'd50,
    parameter logic [9:0] MAX_CLOSE_CNT = 10'd1000,
    parameter logic [9:0] DEFAULT_CLOSE = 10'h100
) (
    input  logic               clk,
    input  logic               reset,
    dv_close_cal_ctrl_if.slave cal
);

    localparam int ACC_W = 13;
    localparam int NPLG  = 6;
    localparam logic [AVG_SHIFT:0] LAST_SAMP = (AVG_SHIFT+1)'((1 << AVG_SHIFT) - 1);

`ifdef DV_CAL_MAX_CHECK_EN
    localparam bit MAX_CHECK = 1'b1;
`else
    localparam bit MAX_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, ACCUM, STORE, NEXT, LOAD} state_t;

    state_t             state;
    logic [2:0]         idx;
    logic [7:0]         settle_cnt;
    logic [AVG_SHIFT:0] samp_cnt;
    logic [ACC_W-1:0]   acc;
    logic [9:0]         sense_sel;
    logic [9:0]         avg;
    logic               avg_ok;

    always_comb begin
        sense_sel = cal.sense[10*idx +: 10];
        avg       = 10'(acc >> AVG_SHIFT);
        // Upper bound only participates when the max check is compiled in.
        avg_ok    = (avg >= MIN_CLOSE_CNT) && !(MAX_CHECK && (avg > MAX_CLOSE_CNT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            settle_cnt    <= 8'd0;
            samp_cnt      <= '0;
            acc           <= '0;
            cal.valve_cmd <= 6'b0;
            cal.close_val <= {NPLG{DEFAULT_CLOSE}};
            cal.strb_load <= 1'b0;
            cal.cal_busy  <= 1'b0;
            cal.cal_done  <= 1'b0;
            cal.cal_err   <= 6'b0;
        end else begin
            cal.strb_load <= 1'b0;
            if (cal.cal_abort && state != IDLE) begin
                state         <= IDLE;
                cal.valve_cmd <= 6'b0;
                cal.cal_busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cal.cal_start && !cal.cal_abort) begin
                            idx          <= 3'd0;
                            cal.cal_done <= 1'b0;
                            cal.cal_err  <= 6'b0;
                            cal.cal_busy <= 1'b1;
                            state        <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        cal.valve_cmd <= 6'b000001 << idx;
                        settle_cnt    <= 8'd0;
                        state         <= SETTLE;
                    end
                    SETTLE: begin
                        if (cal.sample_strb) begin
                            // The strobe that ends settling is not accumulated.
                            if (settle_cnt == SETTLE_TICKS - 8'd1) begin
                                acc      <= '0;
                                samp_cnt <= '0;
                                state    <= ACCUM;
                            end else begin
                                settle_cnt <= settle_cnt + 8'd1;
                            end
                        end
                    end
                    ACCUM: begin
                        if (cal.sample_strb) begin
                            acc <= acc + ACC_W'(sense_sel);
                            if (samp_cnt == LAST_SAMP) begin
                                state <= STORE;
                            end else begin
                                samp_cnt <= samp_cnt + (AVG_SHIFT+1)'(1);
                            end
                        end
                    end
                    STORE: begin
                        if (avg_ok) begin
                            cal.close_val[10*idx +: 10] <= avg;
                        end else begin
                            cal.cal_err[idx] <= 1'b1;
                        end
                        state <= NEXT;
                    end
                    NEXT: begin
                        cal.valve_cmd <= 6'b0;
                        if (idx == 3'd5) begin
                            state <= LOAD;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= DRIVE;
                        end
                    end
                    LOAD: begin
                        cal.strb_load <= 1'b1;
                        cal.cal_done  <= 1'b1;
                        cal.cal_busy  <= 1'b0;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dv_close_cal_ctrl.sv
// Bench for dv_close_cal_ctrl: table vectors, hand-written corner sequences and randomized runs against a sample-schedule model.
module tb_dv_close_cal_ctrl;

    localparam int         ST  = 3;
    localparam int         NPH = ST + 4;
    localparam logic [9:0] DEF = 10'h100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dv_close_cal_ctrl_if bus();

    dv_close_cal_ctrl #(.SETTLE_TICKS(8'(ST))) dut (
        .clk   (clk),
        .reset (reset),
        .cal   (bus)
    );

    int checks = 0;
    int errors = 0;
    int strb_cnt = 0;
    int onehot_viol = 0;

    logic [9:0] smp [6][NPH];
    logic [9:0] exp_close [6];
    logic [5:0] exp_err;

    typedef struct {
        logic [59:0] sense;
        logic [59:0] exp_close;
        logic [5:0]  exp_err;
    } vec_t;
    vec_t vecs [4];

    always @(negedge clk) begin
        if (bus.strb_load === 1'b1) strb_cnt++;
        if ($countones(bus.valve_cmd) > 1) onehot_viol++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [59:0] pk6(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
        return {10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic logic [59:0] exp_vec();
        logic [59:0] v;
        for (int p = 0; p < 6; p++) v[10*p +: 10] = exp_close[p];
        return v;
    endfunction

    function automatic logic [59:0] rnd60();
        return 60'({$urandom(), $urandom()});
    endfunction

    task automatic do_reset();
        bus.sample_strb = 1'b0;
        bus.cal_start   = 1'b0;
        bus.cal_abort   = 1'b0;
        bus.sense       = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int p = 0; p < 6; p++) exp_close[p] = DEF;
        exp_err = 6'b0;
    endtask

    task automatic fill_const(input logic [59:0] s);
        for (int p = 0; p < 6; p++)
            for (int ph = 0; ph < NPH; ph++)
                smp[p][ph] = s[10*p +: 10];
    endtask

    // Reference: plunger p's limit is the integer mean of the four samples that follow its settle strobes.
    task automatic model_update(input int n_done);
        for (int p = 0; p < n_done; p++) begin
            int sum = 0;
            int avg;
            bit ok;
            for (int ph = ST; ph < NPH; ph++) sum += int'(smp[p][ph]);
            avg = sum / 4;
            ok  = (avg >= 50);
`ifdef DV_CAL_MAX_CHECK_EN
            ok  = ok && (avg <= 1000);
`endif
            if (ok) exp_close[p] = 10'(avg);
            else    exp_err[p]   = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_close_val"}, 64'(bus.close_val), 64'(exp_vec()));
        chk({tag, "_cal_err"},   64'(bus.cal_err),   64'(exp_err));
    endtask

    task automatic run_cal(input string tag, input bit spurious, input int abort_p, input bit busy_start);
        int base = strb_cnt;
        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        tick();
        chk({tag, "_busy_on"},  64'(bus.cal_busy), 64'(1));
        chk({tag, "_done_clr"}, 64'(bus.cal_done), 64'(0));
        chk({tag, "_err_clr"},  64'(bus.cal_err),  64'(0));
        exp_err = 6'b0;
        for (int p = 0; p < 6; p++) begin
            for (int ph = 0; ph < NPH; ph++) begin
                if (ph == 0) chk($sformatf("%s_valve%0d", tag, p), 64'(bus.valve_cmd), 64'(6'b1 << p));
                if (p == abort_p && ph == ST + 2) begin
                    bus.cal_abort = 1'b1;
                    tick();
                    bus.cal_abort = 1'b0;
                    chk({tag, "_abort_valve"}, 64'(bus.valve_cmd), 64'(0));
                    chk({tag, "_abort_busy"},  64'(bus.cal_busy),  64'(0));
                    tick();
                    tick();
                    chk({tag, "_abort_noload"}, 64'(strb_cnt - base), 64'(0));
                    chk({tag, "_abort_done"},   64'(bus.cal_done),    64'(0));
                    model_update(p);
                    compare_model(tag);
                    return;
                end
                bus.sense = rnd60();
                bus.sense[10*p +: 10] = smp[p][ph];
                bus.sample_strb = 1'b1;
                tick();
                bus.sense = rnd60();
                if (spurious && ph == NPH - 1) begin
                    // Strobes held through STORE, NEXT and DRIVE must be ignored.
                    repeat (3) tick();
                    bus.sample_strb = 1'b0;
                end else begin
                    bus.sample_strb = 1'b0;
                    if (busy_start && p == 1 && ph == 0) begin
                        bus.cal_start = 1'b1;
                        tick();
                        bus.cal_start = 1'b0;
                        repeat (2) tick();
                    end else begin
                        repeat (3) tick();
                    end
                end
            end
        end
        tick();
        tick();
        chk({tag, "_one_load"}, 64'(strb_cnt - base), 64'(1));
        chk({tag, "_done"},     64'(bus.cal_done),    64'(1));
        chk({tag, "_busy_off"}, 64'(bus.cal_busy),    64'(0));
        chk({tag, "_valve_off"},64'(bus.valve_cmd),   64'(0));
        model_update(6);
        compare_model(tag);
    endtask

    initial begin
        logic [59:0] cv;

        vecs[0] = '{pk6(400,400,400,400,400,400), pk6(400,400,400,400,400,400), 6'b000000};
        vecs[1] = '{pk6(400,400,400,30,400,400),  pk6(400,400,400,256,400,400), 6'b001000};
`ifdef DV_CAL_MAX_CHECK_EN
        vecs[2] = '{pk6(400,400,400,400,400,1010), pk6(400,400,400,400,400,256), 6'b100000};
        vecs[3] = '{pk6(50,49,1000,1023,0,51),     pk6(50,256,1000,256,256,51),  6'b011010};
`else
        vecs[2] = '{pk6(400,400,400,400,400,1010), pk6(400,400,400,400,400,1010), 6'b000000};
        vecs[3] = '{pk6(50,49,1000,1023,0,51),     pk6(50,256,1000,1023,256,51),  6'b010010};
`endif

        bus.sample_strb = 1'b0;
        bus.cal_start   = 1'b0;
        bus.cal_abort   = 1'b0;
        bus.sense       = '0;
        reset = 1'b1;
        #12;
        chk("rst_close_val", 64'(bus.close_val), 64'(pk6(256,256,256,256,256,256)));
        chk("rst_valve",     64'(bus.valve_cmd), 64'(0));
        chk("rst_busy",      64'(bus.cal_busy),  64'(0));
        chk("rst_done",      64'(bus.cal_done),  64'(0));
        chk("rst_err",       64'(bus.cal_err),   64'(0));
        chk("rst_load",      64'(bus.strb_load), 64'(0));
        do_reset();

        bus.cal_start = 1'b1;
        bus.cal_abort = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        bus.cal_abort = 1'b0;
        tick();
        chk("start_abort_busy",  64'(bus.cal_busy),  64'(0));
        chk("start_abort_valve", 64'(bus.valve_cmd), 64'(0));

        for (int i = 0; i < 4; i++) begin
            do_reset();
            fill_const(vecs[i].sense);
            run_cal($sformatf("vec%0d", i), i == 0, -1, 1'b0);
            chk($sformatf("vec%0d_tbl_close", i), 64'(bus.close_val), 64'(vecs[i].exp_close));
            chk($sformatf("vec%0d_tbl_err", i),   64'(bus.cal_err),   64'(vecs[i].exp_err));
        end

        do_reset();
        fill_const(pk6(400,400,400,400,400,400));
        for (int k = 0; k < 4; k++) smp[2][ST + k] = 10'(200 + k);
        run_cal("j5avg", 1'b0, -1, 1'b0);
        cv = bus.close_val;
        chk("j5avg_tbl", 64'(cv[29:20]), 64'(201));

        do_reset();
        fill_const(pk6(300,310,320,330,340,350));
        run_cal("abort", 1'b0, 4, 1'b1);
        cv = bus.close_val;
        chk("abort_j6_kept", 64'(cv[39:30]), 64'(330));
        chk("abort_j7_def",  64'(cv[49:40]), 64'(DEF));
        chk("abort_j8_def",  64'(cv[59:50]), 64'(DEF));

        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        tick();
        bus.sample_strb = 1'b1;
        tick();
        bus.sample_strb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valve", 64'(bus.valve_cmd), 64'(0));
        chk("midrst_busy",  64'(bus.cal_busy),  64'(0));
        chk("midrst_close", 64'(bus.close_val), 64'(pk6(256,256,256,256,256,256)));
        do_reset();

        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 6; p++) begin
                int base;
                case ($urandom_range(0, 2))
                    0:       base = int'($urandom_range(30, 70));
                    1:       base = int'($urandom_range(980, 1020));
                    default: base = int'($urandom_range(0, 1020));
                endcase
                for (int ph = 0; ph < NPH; ph++) smp[p][ph] = 10'(base + int'($urandom_range(0, 3)));
            end
            run_cal($sformatf("rnd%0d", r), r[0], -1, 1'b0);
        end

        chk("valve_onehot", 64'(onehot_viol), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
